// File: rtl/tx_fifo_width_down_if.sv
// tx_fifo_width_down_if
//   Handshake bundle between a wide-word producer and a narrow-lane consumer.
//   master modport: the side driving writes and read acknowledges (testbench / upstream).
//   slave modport : the FIFO itself.
//   Signals:
//     wr_en   write request, accepted on a rising edge only while wr_vld=1
//     wr_vld  space available in word storage
//     wr_data write word (WR_DATA_WIDTH bits)
//     rd_en   read acknowledge, consumes the current lane while rd_vld=1
//     rd_vld  rd_data holds a valid lane
//     rd_data current lane (RD_DATA_WIDTH bits)
//     level   words held in storage, excluding the output holding register
interface tx_fifo_width_down_if #(
  parameter int unsigned DEPTH_WIDTH   = 4,
  parameter int unsigned WR_DATA_WIDTH = 128,
  parameter int unsigned RD_DATA_WIDTH = 8
);

  logic                     wr_en;
  logic                     wr_vld;
  logic [WR_DATA_WIDTH-1:0] wr_data;
  logic                     rd_en;
  logic                     rd_vld;
  logic [RD_DATA_WIDTH-1:0] rd_data;
  logic [DEPTH_WIDTH:0]     level;

  modport master (
    output wr_en,
    output wr_data,
    output rd_en,
    input  wr_vld,
    input  rd_vld,
    input  rd_data,
    input  level
  );

  modport slave (
    input  wr_en,
    input  wr_data,
    input  rd_en,
    output wr_vld,
    output rd_vld,
    output rd_data,
    output level
  );

endinterface

// File: rtl/tx_fifo_width_down.sv
// tx_fifo_width_down
//   Word FIFO with a width-down output stage: WR_DATA_WIDTH words are stored in a circular
//   array and handed out RD_DATA_WIDTH lanes at a time through a holding register
//   (first-word-fall-through on the lane side).
//
//   Ports:
//     clk  single clock for both sides
//     rst  asynchronous active-high reset
//     bus  tx_fifo_width_down_if.slave (wr_en/wr_vld/wr_data, rd_en/rd_vld/rd_data, level)
//
//   Parameters:
//     DEPTH_WIDTH   log2 of the word storage depth (2..10)
//     WR_DATA_WIDTH write word width, RD_DATA_WIDTH * 2^k with k >= 1
//     RD_DATA_WIDTH read lane width
//
//   Build option:
//     TX_FIFO_MSB_FIRST_EN  when defined, lanes are emitted MSB lane first; otherwise the
//                           LSB lane (wr_data[RD_DATA_WIDTH-1:0]) goes out first.
//
//   Timing: a word written into an empty FIFO at edge k shows rd_vld=1 with lane 0 after
//   edge k+2. Once the output stage is running, the last lane of a word and the reload of
//   the next word share one edge, so lanes stream without gaps.
module tx_fifo_width_down #(
  parameter int unsigned DEPTH_WIDTH   = 4,
  parameter int unsigned WR_DATA_WIDTH = 128,
  parameter int unsigned RD_DATA_WIDTH = 8
) (
  input logic                 clk,
  input logic                 rst,
  tx_fifo_width_down_if.slave bus
);

  localparam int unsigned Depth = 1 << DEPTH_WIDTH;
  localparam int unsigned Ratio = WR_DATA_WIDTH / RD_DATA_WIDTH;
  localparam int unsigned LaneW = $clog2(Ratio);

  typedef logic [DEPTH_WIDTH:0]       ptr_t;
  typedef logic [LaneW-1:0]           lane_t;
  typedef logic [WR_DATA_WIDTH-1:0]   word_t;
  typedef logic [RD_DATA_WIDTH-1:0]   byte_t;

  localparam ptr_t  DepthP   = ptr_t'(Depth);
  localparam ptr_t  PtrOne   = ptr_t'(1);
  localparam lane_t LaneZero = '0;
  localparam lane_t LaneOne  = lane_t'(1);
  localparam lane_t LastLane = lane_t'(Ratio - 1);

  // Word storage; contents are deliberately not reset.
  word_t mem [Depth];

  ptr_t  wr_ptr_q, wr_ptr_d;
  ptr_t  rd_ptr_q, rd_ptr_d;
  word_t hold_q, hold_d;
  lane_t lane_q, lane_d;
  logic  hold_vld_q, hold_vld_d;
  byte_t rd_data_q, rd_data_d;
  logic  avail_q;

  ptr_t  level;
  logic  not_empty;
  logic  wr_vld;
  logic  wr_acc;
  logic  rd_acc;
  logic  last_lane;
  logic  load;
  word_t head_word;

  // Pick lane idx out of a word in emission order.
  function automatic byte_t lane_sel(input word_t word, input lane_t idx);
    logic [Ratio-1:0][RD_DATA_WIDTH-1:0] lanes;
    lanes = word;
`ifdef TX_FIFO_MSB_FIRST_EN
    return lanes[LastLane - idx];
`else
    return lanes[idx];
`endif
  endfunction

  // Pointer difference is exact because both pointers carry one extra wrap bit.
  assign level     = wr_ptr_q - rd_ptr_q;
  assign not_empty = (level != '0);
  assign wr_vld    = (level < DepthP);
  assign head_word = mem[rd_ptr_q[DEPTH_WIDTH-1:0]];

  assign wr_acc    = bus.wr_en && wr_vld;
  assign rd_acc    = bus.rd_en && hold_vld_q;
  assign last_lane = (lane_q == LastLane);

  // An idle holding register only picks up a word that has been in storage for a full
  // cycle (avail_q), which fixes the empty-FIFO latency at two edges. A running holding
  // register reloads on the edge that consumes its last lane, keeping the stream gapless.
  assign load = not_empty && ((!hold_vld_q && avail_q) || (rd_acc && last_lane));

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    hold_d     = hold_q;
    lane_d     = lane_q;
    hold_vld_d = hold_vld_q;
    rd_data_d  = rd_data_q;

    if (wr_acc) begin
      wr_ptr_d = wr_ptr_q + PtrOne;
    end

    if (load) begin
      rd_ptr_d   = rd_ptr_q + PtrOne;
      hold_d     = head_word;
      lane_d     = LaneZero;
      hold_vld_d = 1'b1;
      rd_data_d  = lane_sel(head_word, LaneZero);
    end else if (rd_acc) begin
      if (last_lane) begin
        // Word exhausted and nothing stored: rd_data keeps its last lane.
        lane_d     = LaneZero;
        hold_vld_d = 1'b0;
      end else begin
        lane_d    = lane_q + LaneOne;
        rd_data_d = lane_sel(hold_q, lane_q + LaneOne);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      hold_q     <= '0;
      lane_q     <= '0;
      hold_vld_q <= 1'b0;
      rd_data_q  <= '0;
      avail_q    <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      hold_q     <= hold_d;
      lane_q     <= lane_d;
      hold_vld_q <= hold_vld_d;
      rd_data_q  <= rd_data_d;
      avail_q    <= not_empty;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem[wr_ptr_q[DEPTH_WIDTH-1:0]] <= bus.wr_data;
    end
  end

  assign bus.wr_vld  = wr_vld;
  assign bus.rd_vld  = hold_vld_q;
  assign bus.rd_data = rd_data_q;
  assign bus.level   = level;

endmodule

// File: tb/tb_tx_fifo_width_down.sv
// tb_tx_fifo_width_down
//   Self-checking bench for tx_fifo_width_down. Every accepted write pushes its lanes, in
//   emission order, onto an expected-lane queue; a negedge monitor pops and compares each
//   lane the DUT hands over (rd_vld && rd_en). Directed sequences add latency, full,
//   stability and reset checks; a randomized phase follows.
//   Honours TX_FIFO_MSB_FIRST_EN for the expected lane order.
module tb_tx_fifo_width_down;

  localparam int unsigned DW    = 4;
  localparam int unsigned WRW   = 128;
  localparam int unsigned RDW   = 8;
  localparam int unsigned RATIO = WRW / RDW;
  localparam int unsigned DEPTH = 1 << DW;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  tx_fifo_width_down_if #(
    .DEPTH_WIDTH  (DW),
    .WR_DATA_WIDTH(WRW),
    .RD_DATA_WIDTH(RDW)
  ) bus ();

  tx_fifo_width_down #(
    .DEPTH_WIDTH  (DW),
    .WR_DATA_WIDTH(WRW),
    .RD_DATA_WIDTH(RDW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int checks   = 0;
  int failures = 0;

  logic [RDW-1:0] exp_q[$];

  function automatic logic [RDW-1:0] lane_of(input logic [WRW-1:0] w, input int i);
    int pos;
`ifdef TX_FIFO_MSB_FIRST_EN
    pos = RATIO - 1 - i;
`else
    pos = i;
`endif
    return RDW'(w >> (pos * RDW));
  endfunction

  function automatic logic [WRW-1:0] rand_word();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic check(input string name, input logic [WRW-1:0] act, input logic [WRW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive inputs for the coming edge; record the word if it will be accepted.
  task automatic set_in(input logic w, input logic [WRW-1:0] d, input logic r);
    bus.wr_en   = w;
    bus.wr_data = d;
    bus.rd_en   = r;
    if (w && bus.wr_vld === 1'b1 && rst === 1'b0) begin
      for (int i = 0; i < int'(RATIO); i++) exp_q.push_back(lane_of(d, i));
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Read until storage and holding register are both empty, bounded.
  task automatic drain(input string name);
    int n;
    n = 0;
    set_in(1'b0, '0, 1'b1);
    while ((bus.rd_vld === 1'b1 || bus.level !== '0) && n < 800) begin
      step();
      n++;
    end
    if (n >= 800) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout: got rd_vld=%0b level=%0d expected drained", name, bus.rd_vld,
               bus.level);
    end
    check({name, "_queue_empty"}, WRW'(exp_q.size()), '0);
  endtask

  // Scoreboard monitor.
  always @(negedge clk) begin : monitor
    logic [RDW-1:0] e;
    if (rst === 1'b0 && bus.rd_vld === 1'b1 && bus.rd_en === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL rd_data_unexpected: got %0h expected no lane", bus.rd_data);
      end else begin
        e = exp_q.pop_front();
        if (bus.rd_data !== e) begin
          failures++;
          $display("FAIL rd_data: got %0h expected %0h", bus.rd_data, e);
        end
      end
    end
  end

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    logic [WRW-1:0] w0;
    logic [RDW-1:0] prev;
    int first, last, highs, consumed;
    bit r;

    w0 = 128'h0F0E0D0C0B0A09080706050403020100;
    bus.wr_en   = 1'b0;
    bus.wr_data = '0;
    bus.rd_en   = 1'b0;

    // Reset state
    #1;
    check("reset_rd_vld", WRW'(bus.rd_vld), '0);
    check("reset_wr_vld", WRW'(bus.wr_vld), WRW'(1));
    check("reset_level", WRW'(bus.level), '0);
    check("reset_rd_data", WRW'(bus.rd_data), '0);
    repeat (2) step();
    rst = 1'b0;
    step();

    // Single word, rd_en held: latency and lane order
    set_in(1'b1, w0, 1'b1);
    step();
    set_in(1'b0, '0, 1'b1);
    check("lat_edge_k_rd_vld", WRW'(bus.rd_vld), '0);
    check("lat_edge_k_level", WRW'(bus.level), WRW'(1));
    step();
    check("lat_edge_k1_rd_vld", WRW'(bus.rd_vld), '0);
    step();
    check("lat_edge_k2_rd_vld", WRW'(bus.rd_vld), WRW'(1));
    check("lat_edge_k2_lane0", WRW'(bus.rd_data), WRW'(lane_of(w0, 0)));
    repeat (RATIO) step();
    check("single_end_rd_vld", WRW'(bus.rd_vld), '0);
    check("single_end_level", WRW'(bus.level), '0);
    check("single_end_queue", WRW'(exp_q.size()), '0);
    step();
    check("idle_rd_data_last", WRW'(bus.rd_data), WRW'(lane_of(w0, RATIO - 1)));

    // Three back-to-back words, gapless
    first = -1;
    last  = -1;
    highs = 0;
    for (int i = 0; i < 80; i++) begin
      if (i < 3) set_in(1'b1, rand_word(), 1'b1);
      else set_in(1'b0, '0, 1'b1);
      step();
      if (bus.rd_vld === 1'b1) begin
        if (first < 0) first = i;
        last = i;
        highs++;
      end
    end
    check("b2b_high_cycles", WRW'(highs), WRW'(3 * RATIO));
    check("b2b_gapless_span", WRW'(last - first + 1), WRW'(3 * RATIO));
    drain("b2b");

    // Fill: 17 writes, then an ignored 18th
    for (int i = 0; i < int'(DEPTH) + 1; i++) begin
      set_in(1'b1, rand_word(), 1'b0);
      step();
    end
    check("full_level", WRW'(bus.level), WRW'(DEPTH));
    check("full_wr_vld", WRW'(bus.wr_vld), '0);
    check("full_rd_vld", WRW'(bus.rd_vld), WRW'(1));
    set_in(1'b1, rand_word(), 1'b0);
    step();
    check("full_ignored_level", WRW'(bus.level), WRW'(DEPTH));
    set_in(1'b0, '0, 1'b1);
    repeat (RATIO - 1) step();
    check("full_pre_reload_wr_vld", WRW'(bus.wr_vld), '0);
    step();
    check("full_post_reload_wr_vld", WRW'(bus.wr_vld), WRW'(1));
    check("full_post_reload_level", WRW'(bus.level), WRW'(DEPTH - 1));
    drain("full");

    // rd_en toggling: rd_data held while not acknowledged
    set_in(1'b1, rand_word(), 1'b0);
    step();
    set_in(1'b0, '0, 1'b0);
    for (int i = 0; i < 10 && bus.rd_vld !== 1'b1; i++) step();
    for (int i = 0; i < 40 && bus.rd_vld === 1'b1; i++) begin
      r = (i % 2 == 0);
      set_in(1'b0, '0, r);
      prev = bus.rd_data;
      step();
      if (!r) check("toggle_hold_stable", WRW'(bus.rd_data), WRW'(prev));
    end
    check("toggle_queue_empty", WRW'(exp_q.size()), '0);
    drain("toggle");

    // Reset mid-stream after 5 lanes
    set_in(1'b1, rand_word(), 1'b1);
    step();
    set_in(1'b1, rand_word(), 1'b1);
    step();
    set_in(1'b0, '0, 1'b1);
    consumed = 0;
    for (int i = 0; i < 30 && consumed < 5; i++) begin
      if (bus.rd_vld === 1'b1) consumed++;
      step();
    end
    rst = 1'b1;
    exp_q.delete();
    #1;
    check("midrst_rd_vld", WRW'(bus.rd_vld), '0);
    check("midrst_level", WRW'(bus.level), '0);
    check("midrst_wr_vld", WRW'(bus.wr_vld), WRW'(1));
    check("midrst_rd_data", WRW'(bus.rd_data), '0);
    set_in(1'b0, '0, 1'b0);
    step();
    rst = 1'b0;
    step();
    set_in(1'b1, {16{8'hAA}}, 1'b1);
    step();
    set_in(1'b0, '0, 1'b1);
    step();
    step();
    check("postrst_lane0", WRW'(bus.rd_data), WRW'(8'hAA));
    drain("postrst");

    // Randomized traffic: slow reader first, then fast reader
    for (int i = 0; i < 600; i++) begin
      if (i < 300) set_in(1'($urandom_range(0, 1)), rand_word(), ($urandom_range(0, 3) == 0));
      else set_in(($urandom_range(0, 3) == 0), rand_word(), ($urandom_range(0, 3) != 0));
      step();
    end
    drain("random");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
